permute_issue_ctrl: RTL and testbench

Issue controller for the odd-pipe Permute unit in the SPU. It accepts decoded instructions from decode over a valid/ready handshake and holds at most one. It stalls that instruction while a source register is still being produced inside the Permute pipeline, where only the WB result is forwardable. It then drives the Permute RF/FWD-stage inputs, emitting a NOP (op = 0, reg_write = 0) on every cycle with no issue.

---
 rtl/permute_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_permute_issue_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/permute_issue_ctrl.sv
// permute_issue_ctrl
//   Issue controller for the odd-pipe Permute unit. Holds at most one decoded
//   instruction, stalls it while a source register is still in flight inside
//   the Permute pipe (only the WB result is forwardable), and drives the
//   Permute RF/FWD-stage inputs. A NOP (op = 0, reg_write = 0) goes out on
//   every cycle without an issue.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   in_valid/in_ready   decode handshake
//   in_*                decoded instruction fields
//   flush               drop the held, not-yet-issued instruction
//   op..reg_write       registered outputs to Permute / RF read ports
//   issue_cnt           instructions issued (wraps)
//   stall_cnt           cycles a held instruction was hazard-blocked (wraps)
module permute_issue_ctrl #(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:10]       in_op,
    input  logic [2:0]        in_format,
    input  logic [0:ADDR_W-1] in_rt_addr,
    input  logic [0:ADDR_W-1] in_ra_addr,
    input  logic [0:ADDR_W-1] in_rb_addr,
    input  logic              in_uses_ra,
    input  logic              in_uses_rb,
    input  logic [0:17]       in_imm,
    input  logic              in_reg_write,
    input  logic              flush,
    output logic [0:10]       op,
    output logic [2:0]        format,
    output logic [0:ADDR_W-1] rt_addr,
    output logic [0:ADDR_W-1] ra_addr,
    output logic [0:ADDR_W-1] rb_addr,
    output logic [0:17]       imm,
    output logic              reg_write,
    output logic [31:0]       issue_cnt,
    output logic [31:0]       stall_cnt
);
    typedef enum logic {EMPTY, HOLD} state_t;

    typedef struct packed {
        logic [0:10]       op;
        logic [2:0]        fmt;
        logic [0:ADDR_W-1] rt;
        logic [0:ADDR_W-1] ra;
        logic [0:ADDR_W-1] rb;
        logic              uses_ra;
        logic              uses_rb;
        logic [0:17]       imm;
        logic              reg_write;
    } instr_t;

    typedef struct packed {
        logic [0:10]       op;
        logic [2:0]        fmt;
        logic [0:ADDR_W-1] rt;
        logic [0:ADDR_W-1] ra;
        logic [0:ADDR_W-1] rb;
        logic [0:17]       imm;
        logic              reg_write;
    } out_t;

    typedef struct packed {
        logic              v;
        logic [0:ADDR_W-1] addr;
    } sb_t;

    state_t      state_q, state_d;
    instr_t      hold_q, hold_d;
    out_t        out_q, out_d;
    sb_t         sb_q [DEPTH-1];
    sb_t         sb_d [DEPTH-1];
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic hit_a, hit_b, hazard, issue_fire, accept;

    always_comb begin
        // Hazard window: the instruction currently on the outputs plus the
        // younger scoreboard entries. The oldest entry has reached WB and is
        // forwardable, so it is deliberately left out of the compare.
        hit_a = out_q.reg_write && (out_q.rt == hold_q.ra);
        hit_b = out_q.reg_write && (out_q.rt == hold_q.rb);
        for (int k = 0; k < DEPTH-2; k++) begin
            if (sb_q[k].v && sb_q[k].addr == hold_q.ra) hit_a = 1'b1;
            if (sb_q[k].v && sb_q[k].addr == hold_q.rb) hit_b = 1'b1;
        end
        hazard     = (hold_q.uses_ra && hit_a) || (hold_q.uses_rb && hit_b);
        issue_fire = (state_q == HOLD) && !hazard && !flush;
        // Flush empties the slot, so ready is reported, but the offer is dropped.
        in_ready   = (state_q == EMPTY) || issue_fire || flush;
        accept     = in_valid && in_ready && !flush;

        state_d = state_q;
        hold_d  = hold_q;
        if (accept) begin
            state_d        = HOLD;
            hold_d.op      = in_op;
            hold_d.fmt     = in_format;
            hold_d.rt      = in_rt_addr;
            hold_d.ra      = in_ra_addr;
            hold_d.rb      = in_rb_addr;
            hold_d.uses_ra = in_uses_ra;
            hold_d.uses_rb = in_uses_rb;
            hold_d.imm     = in_imm;
            hold_d.reg_write = in_reg_write;
        end else if (issue_fire || flush) begin
            state_d = EMPTY;
        end

        // Non-issue cycles only kill op/reg_write; address fields keep their value.
        out_d           = out_q;
        out_d.op        = '0;
        out_d.reg_write = 1'b0;
        if (issue_fire) begin
            out_d.op        = hold_q.op;
            out_d.fmt       = hold_q.fmt;
            out_d.rt        = hold_q.rt;
            out_d.ra        = hold_q.ra;
            out_d.rb        = hold_q.rb;
            out_d.imm       = hold_q.imm;
            out_d.reg_write = hold_q.reg_write;
        end

        sb_d[0].v    = out_q.reg_write;
        sb_d[0].addr = out_q.rt;
        for (int k = 1; k < DEPTH-1; k++) sb_d[k] = sb_q[k-1];

        issue_cnt_d = issue_cnt_q + {31'd0, issue_fire};
        stall_cnt_d = stall_cnt_q + {31'd0, (state_q == HOLD) && hazard && !flush};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            hold_q      <= '0;
            out_q       <= '0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < DEPTH-1; k++) sb_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < DEPTH-1; k++) sb_q[k] <= sb_d[k];
        end
    end

    assign op        = out_q.op;
    assign format    = out_q.fmt;
    assign rt_addr   = out_q.rt;
    assign ra_addr   = out_q.ra;
    assign rb_addr   = out_q.rb;
    assign imm       = out_q.imm;
    assign reg_write = out_q.reg_write;
    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_permute_issue_ctrl.sv
// Bench for permute_issue_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a model that
// tracks, per register, the first edge at which a consumer may issue.
module tb_permute_issue_ctrl;
    localparam int DEPTH  = 3;
    localparam int ADDR_W = 7;

    localparam logic [10:0] SHLH    = 11'h05F;
    localparam logic [10:0] ROTQBI  = 11'h1D8;
    localparam logic [10:0] GBB     = 11'h1B2;
    localparam logic [10:0] ROTQBYI = 11'h1FC;
    localparam logic [10:0] ORX     = 11'h1F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, in_valid, in_ready, in_uses_ra, in_uses_rb, in_reg_write, flush;
    logic [0:10]       in_op, op;
    logic [2:0]        in_format, format;
    logic [0:ADDR_W-1] in_rt_addr, in_ra_addr, in_rb_addr, rt_addr, ra_addr, rb_addr;
    logic [0:17]       in_imm, imm;
    logic              reg_write;
    logic [31:0]       issue_cnt, stall_cnt;

    permute_issue_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_format(in_format), .in_rt_addr(in_rt_addr),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_uses_ra(in_uses_ra),
        .in_uses_rb(in_uses_rb), .in_imm(in_imm), .in_reg_write(in_reg_write),
        .flush(flush), .op(op), .format(format), .rt_addr(rt_addr),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .imm(imm), .reg_write(reg_write),
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [10:0] op;
        logic [2:0]  fmt;
        logic [6:0]  rt, ra, rb;
        logic        ua, ub;
        logic [17:0] imm;
        logic        rw;
    } ins_t;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ins_t        m_h, m_out;
    bit          m_hv;
    logic [31:0] m_ic, m_sc;
    int          ready_at [128];   // first edge a consumer of this reg may issue
    int          e = 0;            // edges seen so far
    bit          m_fire, m_haz, m_ready, m_acc;

    bit   cur_v, cur_fl, cur_rs;
    ins_t cur_i;

    task automatic model_eval();
        bit ok;
        ok = (!m_h.ua || (e + 1 >= ready_at[m_h.ra])) &&
             (!m_h.ub || (e + 1 >= ready_at[m_h.rb]));
        m_fire  = m_hv && ok && !cur_fl;
        m_haz   = m_hv && !ok;
        m_ready = !m_hv || m_fire || cur_fl;
        m_acc   = cur_v && m_ready && !cur_fl;
    endtask

    task automatic model_commit();
        e++;
        if (!cur_rs) begin
            m_hv = 0;
            m_out = '{default: 0};
            m_ic = 0;
            m_sc = 0;
            foreach (ready_at[r]) ready_at[r] = 0;
        end else begin
            if (m_fire) begin
                m_out = m_h;
                m_ic++;
                if (m_h.rw) ready_at[m_h.rt] = e + DEPTH;
            end else begin
                m_out.op = 0;
                m_out.rw = 0;
            end
            if (m_haz && !cur_fl) m_sc++;
            if (m_acc) begin
                m_hv = 1;
                m_h  = cur_i;
            end else if (m_fire || cur_fl) begin
                m_hv = 0;
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("op",        32'(op),        32'(m_out.op));
            chk("format",    32'(format),    32'(m_out.fmt));
            chk("rt_addr",   32'(rt_addr),   32'(m_out.rt));
            chk("ra_addr",   32'(ra_addr),   32'(m_out.ra));
            chk("rb_addr",   32'(rb_addr),   32'(m_out.rb));
            chk("imm",       32'(imm),       32'(m_out.imm));
            chk("reg_write", 32'(reg_write), 32'(m_out.rw));
            chk("issue_cnt", issue_cnt,      m_ic);
            chk("stall_cnt", stall_cnt,      m_sc);
            if (reset) chk("in_ready", 32'(in_ready), 32'(m_ready));
        end
    end

    // ---------------- stimulus ----------------
    function automatic ins_t mk(input logic [10:0] o, input logic [6:0] rt, input logic [6:0] ra,
                                input logic [6:0] rb, input logic ua, input logic ub,
                                input logic rw, input logic [17:0] im);
        ins_t i;
        i.op = o; i.fmt = ub ? 3'd0 : 3'd1; i.rt = rt; i.ra = ra; i.rb = rb;
        i.ua = ua; i.ub = ub; i.imm = im; i.rw = rw;
        return i;
    endfunction

    task automatic step(input logic v, input ins_t i, input logic fl, input logic rs);
        cur_v = v; cur_i = i; cur_fl = fl; cur_rs = rs;
        in_valid = v; in_op = i.op; in_format = i.fmt; in_rt_addr = i.rt;
        in_ra_addr = i.ra; in_rb_addr = i.rb; in_uses_ra = i.ua; in_uses_rb = i.ub;
        in_imm = i.imm; in_reg_write = i.rw; flush = fl; reset = rs;
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    ins_t nop_i, shlh_i, gbb_i;

    initial begin
        nop_i  = mk(11'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 18'd0);
        shlh_i = mk(SHLH, 7'd3, 7'd1, 7'd2, 1'b1, 1'b1, 1'b1, 18'd0);
        gbb_i  = mk(GBB,  7'd6, 7'd3, 7'd0, 1'b1, 1'b0, 1'b1, 18'd0);
        m_hv = 0; m_h = nop_i; m_out = nop_i; m_ic = 0; m_sc = 0;
        foreach (ready_at[r]) ready_at[r] = 0;

        // Reset for two cycles while decode is offering an instruction.
        step(1, shlh_i, 0, 0);
        chk_en = 1;
        step(1, shlh_i, 0, 0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_issue_cnt", issue_cnt, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step(0, nop_i, 0, 1);
        chk("rst_no_accept_op", 32'(op), 32'd0);
        chk("rst_no_accept_cnt", issue_cnt, 32'd0);

        // Back-to-back independent instructions.
        step(0, nop_i, 0, 0);
        step(1, shlh_i, 0, 1);
        step(1, mk(ROTQBI, 7'd5, 7'd4, 7'd6, 1, 1, 1, 18'd0), 0, 1);
        chk("b2b_op1", 32'(op), 32'(SHLH));
        step(0, nop_i, 0, 1);
        chk("b2b_op2", 32'(op), 32'(ROTQBI));
        chk("b2b_issue", issue_cnt, 32'd2);
        chk("b2b_stall", stall_cnt, 32'd0);

        // RAW on r3: gbb issues three edges after shlh.
        step(0, nop_i, 0, 0);
        step(1, shlh_i, 0, 1);
        step(1, gbb_i, 0, 1);
        chk("raw_prod", 32'(op), 32'(SHLH));
        chk("raw_ready0", 32'(in_ready), 32'd0);
        step(0, nop_i, 0, 1);
        chk("raw_nop1", 32'(op), 32'd0);
        chk("raw_ready1", 32'(in_ready), 32'd0);
        step(0, nop_i, 0, 1);
        chk("raw_nop2", 32'(op), 32'd0);
        step(0, nop_i, 0, 1);
        chk("raw_cons", 32'(op), 32'(GBB));
        chk("raw_stall", stall_cnt, 32'd2);
        chk("pin_model_stall", m_sc, 32'd2);
        chk("raw_issue", issue_cnt, 32'd2);

        // rb matches but is not read: no stall.
        step(0, nop_i, 0, 0);
        step(1, shlh_i, 0, 1);
        step(1, mk(ROTQBYI, 7'd6, 7'd4, 7'd3, 1, 0, 1, 18'd3), 0, 1);
        step(0, nop_i, 0, 1);
        chk("ri7_op", 32'(op), 32'(ROTQBYI));
        chk("ri7_stall", stall_cnt, 32'd0);

        // Producer without reg_write does not block.
        step(0, nop_i, 0, 0);
        step(1, mk(SHLH, 7'd3, 7'd1, 7'd2, 1, 1, 0, 18'd0), 0, 1);
        step(1, gbb_i, 0, 1);
        step(0, nop_i, 0, 1);
        chk("nowr_op", 32'(op), 32'(GBB));
        chk("nowr_stall", stall_cnt, 32'd0);
        chk("pin_model_nowr", m_sc, 32'd0);

        // Flush in the first stall cycle; the offered instruction is dropped.
        step(0, nop_i, 0, 0);
        step(1, shlh_i, 0, 1);
        step(1, gbb_i, 0, 1);
        step(1, mk(ORX, 7'd9, 7'd8, 7'd7, 1, 1, 1, 18'd0), 1, 1);
        chk("fl_op", 32'(op), 32'd0);
        chk("fl_rw", 32'(reg_write), 32'd0);
        chk("fl_issue", issue_cnt, 32'd1);
        chk("fl_stall", stall_cnt, 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        step(1, mk(ROTQBI, 7'd5, 7'd4, 7'd6, 1, 1, 1, 18'd0), 0, 1);
        step(0, nop_i, 0, 1);
        chk("fl_new_op", 32'(op), 32'(ROTQBI));
        chk("fl_new_issue", issue_cnt, 32'd2);
        step(0, nop_i, 0, 1);
        step(0, nop_i, 0, 1);
        chk("fl_gone", issue_cnt, 32'd2);

        // Reset mid-stall.
        step(0, nop_i, 0, 0);
        step(1, shlh_i, 0, 1);
        step(1, gbb_i, 0, 1);
        step(0, nop_i, 0, 1);
        chk("ms_stall1", stall_cnt, 32'd1);
        step(0, nop_i, 0, 0);
        chk("ms_op", 32'(op), 32'd0);
        chk("ms_rt", 32'(rt_addr), 32'd0);
        chk("ms_issue", issue_cnt, 32'd0);
        chk("ms_stall", stall_cnt, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, nop_i, 0, 1);
            chk("ms_never", 32'(op), 32'd0);
        end
        chk("ms_issue_after", issue_cnt, 32'd0);

        // Randomized traffic with a small register pool to create hazards.
        for (int n = 0; n < 3000; n++) begin
            ins_t r;
            r.op  = 11'($urandom);
            r.fmt = 3'($urandom);
            r.rt  = 7'($urandom_range(0, 7));
            r.ra  = 7'($urandom_range(0, 7));
            r.rb  = 7'($urandom_range(0, 7));
            r.ua  = 1'($urandom_range(0, 3) != 0);
            r.ub  = 1'($urandom_range(0, 1));
            r.imm = 18'($urandom);
            r.rw  = 1'($urandom_range(0, 4) != 0);
            step(1'($urandom_range(0, 9) < 7), r,
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 99) != 0));
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
